// File: rtl/ysyx_20020207_axi_sram.sv
// ysyx_20020207_axi_sram: AXI4 slave over a 64-bit on-chip SRAM.
// Independent read and write FSMs, one outstanding transaction each, OKAY/SLVERR responses.
module ysyx_20020207_axi_sram #(
  parameter logic [31:0] BASE_ADDR  = 32'h0f00_0000,
  parameter int          DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic [3:0]  awid,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  output logic        wready,
  input  logic [63:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wlast,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  output logic [3:0]  bid,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  input  logic [3:0]  arid,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  output logic        rvalid,
  input  logic        rready,
  output logic [63:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic [3:0]  rid
);
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;
  localparam logic [31:0] MEM_BYTES = 32'd1 << (DEPTH_LOG2 + 3);

  logic [63:0] r_mem [0:(1 << DEPTH_LOG2) - 1];
  logic        r_en;
  wstate_t     r_wst, w_wst_nx;
  rstate_t     r_rst, w_rst_nx;
  logic [31:0] r_waddr, r_raddr;
  logic [3:0]  r_wid, r_rid;
  logic [7:0]  r_wlen, r_rlen, r_wcnt, r_rcnt;
  logic [2:0]  r_wsize, r_rsize;
  logic        r_wfix, r_rfix, r_wterr, r_rterr, r_werr;
  logic [63:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        r_rlast;

  logic        w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;
  logic        w_wlast_beat, w_rlast_beat, w_wok, w_rbad, w_rload, w_rsel_terr;
  logic [31:0] w_woff, w_roff, w_wnext, w_rnext, w_rsel_addr;

  assign awready = r_en && r_wst == W_IDLE;
  assign wready  = r_wst == W_DATA;
  assign bvalid  = r_wst == W_RESP;
  assign bresp   = (r_wst == W_RESP && r_werr) ? 2'b10 : 2'b00;
  assign bid     = r_wid;
  assign arready = r_en && r_rst == R_IDLE;
  assign rvalid  = r_rst == R_DATA;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign rlast   = r_rlast;
  assign rid     = r_rid;

  assign w_aw_hs = awvalid && awready;
  assign w_w_hs  = wvalid && wready;
  assign w_b_hs  = bvalid && bready;
  assign w_ar_hs = arvalid && arready;
  assign w_r_hs  = rvalid && rready;

  assign w_wlast_beat = r_wcnt == r_wlen;
  assign w_rlast_beat = r_rcnt == r_rlen;
  assign w_woff       = r_waddr - BASE_ADDR;
  assign w_wok        = !r_wterr && w_woff < MEM_BYTES;
  assign w_wnext      = r_wfix ? r_waddr : r_waddr + (32'd1 << r_wsize);
  assign w_rnext      = r_rfix ? r_raddr : r_raddr + (32'd1 << r_rsize);

  // The read port samples either the new AR address or the following beat's address.
  assign w_rsel_addr = r_rst == R_IDLE ? araddr : w_rnext;
  assign w_rsel_terr = r_rst == R_IDLE ? (arburst[1] || arsize[2]) : r_rterr;
  assign w_roff      = w_rsel_addr - BASE_ADDR;
  assign w_rbad      = w_rsel_terr || !(w_roff < MEM_BYTES);
  assign w_rload     = w_ar_hs || (w_r_hs && !w_rlast_beat);

  always_comb begin
    w_wst_nx = r_wst;
    case (r_wst)
      W_IDLE:  if (w_aw_hs) w_wst_nx = W_DATA;
      W_DATA:  if (w_w_hs && w_wlast_beat) w_wst_nx = W_RESP;
      W_RESP:  if (w_b_hs) w_wst_nx = W_IDLE;
      default: w_wst_nx = W_IDLE;
    endcase
  end

  always_comb begin
    w_rst_nx = r_rst;
    case (r_rst)
      R_IDLE:  if (w_ar_hs) w_rst_nx = R_DATA;
      R_DATA:  if (w_r_hs && w_rlast_beat) w_rst_nx = R_IDLE;
      default: w_rst_nx = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en    <= 1'b0;
      r_wst   <= W_IDLE;
      r_waddr <= '0;
      r_wid   <= '0;
      r_wlen  <= '0;
      r_wsize <= '0;
      r_wfix  <= 1'b0;
      r_wterr <= 1'b0;
      r_werr  <= 1'b0;
      r_wcnt  <= '0;
    end else begin
      r_en  <= 1'b1;
      r_wst <= w_wst_nx;
      if (w_aw_hs) begin
        r_waddr <= awaddr;
        r_wid   <= awid;
        r_wlen  <= awlen;
        r_wsize <= awsize;
        r_wfix  <= awburst == 2'b00;
        r_wterr <= awburst[1] || awsize[2];
        r_werr  <= awburst[1] || awsize[2];
        r_wcnt  <= '0;
      end
      if (w_w_hs) begin
        r_waddr <= w_wnext;
        r_wcnt  <= r_wcnt + 8'd1;
        if (!(w_woff < MEM_BYTES) || wlast != w_wlast_beat) r_werr <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_w_hs && w_wok)
      for (int i = 0; i < 8; i++)
        if (wstrb[i]) r_mem[w_woff[DEPTH_LOG2+2:3]][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst   <= R_IDLE;
      r_raddr <= '0;
      r_rid   <= '0;
      r_rlen  <= '0;
      r_rsize <= '0;
      r_rfix  <= 1'b0;
      r_rterr <= 1'b0;
      r_rcnt  <= '0;
      r_rdata <= '0;
      r_rresp <= '0;
      r_rlast <= 1'b0;
    end else begin
      r_rst <= w_rst_nx;
      if (w_ar_hs) begin
        r_rid   <= arid;
        r_rlen  <= arlen;
        r_rsize <= arsize;
        r_rfix  <= arburst == 2'b00;
        r_rterr <= arburst[1] || arsize[2];
        r_rcnt  <= '0;
      end
      if (w_r_hs) r_rcnt <= r_rcnt + 8'd1;
      if (w_r_hs && w_rlast_beat) r_rlast <= 1'b0;
      if (w_rload) begin
        r_raddr <= w_rsel_addr;
        r_rdata <= w_rbad ? 64'd0 : r_mem[w_roff[DEPTH_LOG2+2:3]];
        r_rresp <= w_rbad ? 2'b10 : 2'b00;
        r_rlast <= w_ar_hs ? arlen == 8'd0 : r_rcnt + 8'd1 == r_rlen;
      end
    end
  end
endmodule
